pmcc_matrix_receiver: RTL and testbench

- Pixel-matrix end of the PMC matrix-control bundle (res, write_cfg, strobe, gate, shB, shA, clkSh) driven by the PMC coprocessor.
- Synthesizable digital model of one pixel column, used for FPGA prototyping and for closed-loop verification of coprocessor firmware.
- Decodes the control levels into:
  - a serial configuration chain with a parallel config latch;
  - per-pixel gated hit counters;
  - a serial readout chain.

---
 rtl/pmcc_matrix_receiver_pkg.sv | 26 ++
 rtl/pmcc_matrix_receiver_if.sv | 36 +++
 rtl/pmcc_matrix_receiver_counter.sv | 36 +++
 rtl/pmcc_matrix_receiver.sv | 127 ++++++++++++
 tb/tb_pmcc_matrix_receiver.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pmcc_matrix_receiver_pkg.sv
// Shared definitions for the PMC matrix-control bundle, pixel-column side.
// Holds the default geometry and the bit map of the 16-bit control word.
// The controller side uses the same control-word map.
package pmcc_matrix_pkg;

  localparam int DEF_PIXELS   = 8;
  localparam int DEF_CFG_BITS = 8;
  localparam int DEF_CNT_BITS = 8;

  localparam int CFG_LEN = DEF_PIXELS * DEF_CFG_BITS;
  localparam int CNT_LEN = DEF_PIXELS * DEF_CNT_BITS;

  // 16-bit control word bit positions
  localparam int RES_MSB   = 15;
  localparam int RES_LSB   = 6;
  localparam int WRITE_CFG = 5;
  localparam int STROBE    = 4;
  localparam int GATE      = 3;
  localparam int SHB       = 2;
  localparam int SHA       = 1;
  localparam int CLKSH     = 0;

  localparam int RES_W  = RES_MSB - RES_LSB + 1;
  localparam int CTRL_W = 16;

endpackage

// File: rtl/pmcc_matrix_receiver_if.sv
// Matrix-control bundle between the PMC coprocessor (master) and one pixel
// column (slave).
//   master drives: clk_sh, sh_a, sh_b, write_cfg, strobe, gate, res, din, hit
//   slave drives : dout, cfg, res_q, conflict
interface pmcc_matrix_if
  import pmcc_matrix_pkg::*;
#(
  parameter int PIXELS   = DEF_PIXELS,
  parameter int CFG_BITS = DEF_CFG_BITS
);

  logic                         clk_sh;
  logic                         sh_a;
  logic                         sh_b;
  logic                         write_cfg;
  logic                         strobe;
  logic                         gate;
  logic [RES_W-1:0]             res;
  logic                         din;
  logic [PIXELS-1:0]            hit;
  logic                         dout;
  logic [PIXELS*CFG_BITS-1:0]   cfg;
  logic [RES_W-1:0]             res_q;
  logic                         conflict;

  modport master (
    output clk_sh, sh_a, sh_b, write_cfg, strobe, gate, res, din, hit,
    input  dout, cfg, res_q, conflict
  );

  modport slave (
    input  clk_sh, sh_a, sh_b, write_cfg, strobe, gate, res, din, hit,
    output dout, cfg, res_q, conflict
  );

endinterface

// File: rtl/pmcc_matrix_receiver_counter.sv
// One pixel's saturating, gated hit counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   en_i     : count this cycle (gate & hit)
//   clr_i    : clear (strobe transfer); a hit in the same cycle leaves 1
//   cnt_o    : current count
module pmcc_pixel_counter #(
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                clr_i,
  output logic [CNT_BITS-1:0] cnt_o
);

  localparam logic [CNT_BITS-1:0] ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      // the value being transferred excludes this cycle's hit; it restarts the count
      cnt_d = en_i ? ONE : '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pmcc_matrix_receiver.sv
// Pixel-column end of the PMC matrix-control bundle.
// Registers the control levels once, detects rising edges against a delayed
// copy, and drives a serial config chain with parallel latch, per-pixel
// gated hit counters, and a serial readout chain.
//   clk, rst : clock, synchronous active-high reset
//   mx       : control bundle (slave side), see pmcc_matrix_if
module pmcc_matrix_receiver
  import pmcc_matrix_pkg::*;
#(
  parameter int PIXELS   = DEF_PIXELS,
  parameter int CFG_BITS = DEF_CFG_BITS,
  parameter int CNT_BITS = DEF_CNT_BITS
) (
  input  logic          clk,
  input  logic          rst,
  pmcc_matrix_if.slave  mx
);

  localparam int CFG_W = PIXELS * CFG_BITS;
  localparam int CNT_W = PIXELS * CNT_BITS;

  // delayed-copy slots for the edge-detected inputs
  localparam int DLY_CLKSH = 0;
  localparam int DLY_WCFG  = 1;
  localparam int DLY_STRB  = 2;

  // sample stage: the control word as it would travel on the bus
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [2:0]        s_dly_q, s_dly_d;
  logic              s_din_q;

  logic [CFG_W-1:0]  cfg_chain_q, cfg_chain_d;
  logic [CNT_W-1:0]  rd_chain_q, rd_chain_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic              conflict_q, conflict_d;

  logic rise_clk_sh, rise_wcfg, rise_strobe, sel_a, sel_b;

  logic [PIXELS-1:0]               cnt_en;
  logic [PIXELS-1:0][CNT_BITS-1:0] cnt;

  always_comb begin
    s_ctrl_d                  = '0;
    s_ctrl_d[RES_MSB:RES_LSB] = mx.res;
    s_ctrl_d[WRITE_CFG]       = mx.write_cfg;
    s_ctrl_d[STROBE]          = mx.strobe;
    s_ctrl_d[GATE]            = mx.gate;
    s_ctrl_d[SHB]             = mx.sh_b;
    s_ctrl_d[SHA]             = mx.sh_a;
    s_ctrl_d[CLKSH]           = mx.clk_sh;
    s_dly_d[DLY_CLKSH]        = s_ctrl_q[CLKSH];
    s_dly_d[DLY_WCFG]         = s_ctrl_q[WRITE_CFG];
    s_dly_d[DLY_STRB]         = s_ctrl_q[STROBE];
  end

  assign rise_clk_sh = s_ctrl_q[CLKSH]     & ~s_dly_q[DLY_CLKSH];
  assign rise_wcfg   = s_ctrl_q[WRITE_CFG] & ~s_dly_q[DLY_WCFG];
  assign rise_strobe = s_ctrl_q[STROBE]    & ~s_dly_q[DLY_STRB];
  assign sel_a       = s_ctrl_q[SHA] & ~s_ctrl_q[SHB];
  assign sel_b       = s_ctrl_q[SHB] & ~s_ctrl_q[SHA];

  // hit is already synchronous to clk, so it is used raw against the sampled gate
  assign cnt_en = {PIXELS{s_ctrl_q[GATE]}} & mx.hit;

  for (genvar i = 0; i < PIXELS; i++) begin : g_pix
    pmcc_pixel_counter #(.CNT_BITS(CNT_BITS)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .en_i  (cnt_en[i]),
      .clr_i (rise_strobe),
      .cnt_o (cnt[i])
    );
  end

  always_comb begin
    cfg_chain_d = cfg_chain_q;
    if (rise_clk_sh && sel_a)
      cfg_chain_d = {cfg_chain_q[CFG_W-2:0], s_din_q};

    // strobe load takes priority over a coincident readout shift
    rd_chain_d = rd_chain_q;
    if (rise_strobe)
      rd_chain_d = cnt;
    else if (rise_clk_sh && sel_b)
      rd_chain_d = {rd_chain_q[CNT_W-2:0], s_din_q};

    // latch sees the pre-shift chain even when a shift lands on the same edge
    cfg_d = cfg_q;
    res_d = res_q;
    if (rise_wcfg) begin
      cfg_d = cfg_chain_q;
      res_d = s_ctrl_q[RES_MSB:RES_LSB];
    end

    conflict_d = conflict_q | (rise_clk_sh & s_ctrl_q[SHA] & s_ctrl_q[SHB]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ctrl_q    <= '0;
      s_dly_q     <= '0;
      s_din_q     <= 1'b0;
      cfg_chain_q <= '0;
      rd_chain_q  <= '0;
      cfg_q       <= '0;
      res_q       <= '0;
      conflict_q  <= 1'b0;
    end else begin
      s_ctrl_q    <= s_ctrl_d;
      s_dly_q     <= s_dly_d;
      s_din_q     <= mx.din;
      cfg_chain_q <= cfg_chain_d;
      rd_chain_q  <= rd_chain_d;
      cfg_q       <= cfg_d;
      res_q       <= res_d;
      conflict_q  <= conflict_d;
    end
  end

  assign mx.dout     = sel_a ? cfg_chain_q[CFG_W-1] :
                       sel_b ? rd_chain_q[CNT_W-1]  : 1'b0;
  assign mx.cfg      = cfg_q;
  assign mx.res_q    = res_q;
  assign mx.conflict = conflict_q;

endmodule

// File: tb/tb_pmcc_matrix_receiver.sv
// Directed + randomized bench for pmcc_matrix_receiver. The reference model
// tracks chains as shift registers of bits and counters as plain integers.
module tb_pmcc_matrix_receiver;
  import pmcc_matrix_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pmcc_matrix_if #(.PIXELS(8), .CFG_BITS(8)) mx ();

  pmcc_matrix_receiver #(.PIXELS(8), .CFG_BITS(8), .CNT_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .mx  (mx)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] m_cfgc = '0;  // model config chain
  logic [63:0] m_rdc  = '0;  // model readout chain
  logic [63:0] m_cfg  = '0;
  logic [9:0]  m_res  = '0;
  int          m_cnt [8];

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clk_sh(input logic b);
    mx.din = b; mx.clk_sh = 1'b1; tick(2);
    mx.clk_sh = 1'b0; tick(2);
  endtask

  task automatic shift_a(input logic b);
    pulse_clk_sh(b);
    m_cfgc = {m_cfgc[62:0], b};
    chk("cfg_dout", {63'b0, mx.dout}, {63'b0, m_cfgc[63]});
  endtask

  task automatic shift_b(input logic b);
    pulse_clk_sh(b);
    m_rdc = {m_rdc[62:0], b};
  endtask

  task automatic hits(input logic [7:0] pat, input int n);
    mx.hit = pat;
    tick(n);
    for (int i = 0; i < 8; i++) if (pat[i]) m_cnt[i] += n;
    mx.hit = '0;
  endtask

  function automatic logic [63:0] packed_counts();
    logic [63:0] w = '0;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = (m_cnt[i] > 255) ? 8'hFF : 8'(m_cnt[i]);
    return w;
  endfunction

  task automatic do_strobe();
    mx.strobe = 1'b1; tick(2);
    m_rdc = packed_counts();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    mx.strobe = 1'b0; tick(2);
  endtask

  task automatic read_chain(output logic [63:0] w);
    logic b;
    w = '0;
    for (int k = 0; k < 64; k++) begin
      chk("rd_dout", {63'b0, mx.dout}, {63'b0, m_rdc[63]});
      w = {w[62:0], mx.dout};
      b = 1'($urandom);
      shift_b(b);
    end
  endtask

  task automatic write_cfg_pulse(input logic [9:0] r);
    mx.res = r; mx.write_cfg = 1'b1;
    tick(1);
    chk("wcfg_early", mx.cfg, m_cfg);
    tick(1);
    m_cfg = m_cfgc; m_res = r;
    chk("wcfg_cfg", mx.cfg, m_cfg);
    chk("wcfg_res", {54'b0, mx.res_q}, {54'b0, m_res});
    mx.write_cfg = 1'b0; tick(2);
  endtask

  initial begin
    logic [63:0] w, pat, pre;
    logic [9:0]  rr;
    int          n [8];
    logic [7:0]  hp;

    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    mx.clk_sh = 0; mx.sh_a = 0; mx.sh_b = 0; mx.write_cfg = 0; mx.strobe = 0;
    mx.gate = 0; mx.res = '0; mx.din = 0; mx.hit = '0;

    // reset and idle
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
    chk("rst_res_q", {54'b0, mx.res_q}, 64'd0);
    chk("rst_conflict", {63'b0, mx.conflict}, 64'd0);
    for (int c = 0; c < 20; c++) begin
      chk("idle_dout", {63'b0, mx.dout}, 64'd0);
      chk("idle_cfg", mx.cfg, 64'd0);
      tick(1);
    end

    // config load of 0xA5 pattern
    mx.sh_a = 1'b1; tick(2);
    pat = 64'hA5A5_A5A5_A5A5_A5A5;
    for (int k = 63; k >= 0; k--) shift_a(pat[k]);
    write_cfg_pulse(10'h2AB);
    chk("cfg_a5", mx.cfg, 64'hA5A5_A5A5_A5A5_A5A5);

    // counting with saturation, then readout
    mx.sh_a = 1'b0; mx.gate = 1'b1; tick(2);
    hits(8'h09, 5);
    hits(8'h01, 295);
    do_strobe();
    mx.sh_b = 1'b1; tick(2);
    read_chain(w);
    for (int i = 0; i < 8; i++)
      chk($sformatf("sat_pix%0d", i), {56'b0, w[i*8 +: 8]},
          {56'b0, (i == 0) ? 8'hFF : (i == 3) ? 8'h05 : 8'h00});
    do_strobe();
    read_chain(w);
    chk("cnt_cleared", w, 64'd0);

    // fill readout chain with MSB=1, next=0, so any stray shift shows on dout
    shift_b(1'b1); shift_b(1'b0);
    for (int k = 0; k < 62; k++) shift_b(1'($urandom));

    // conflict: both selects high
    mx.sh_a = 1'b1; tick(2);
    chk("both_dout", {63'b0, mx.dout}, 64'd0);
    pulse_clk_sh(1'b1);
    chk("conflict_set", {63'b0, mx.conflict}, 64'd1);
    mx.sh_b = 1'b0; tick(2);
    chk("conf_cfgc", {63'b0, mx.dout}, {63'b0, m_cfgc[63]});
    mx.sh_a = 1'b0; mx.sh_b = 1'b1; tick(2);
    chk("conf_rdc", {63'b0, mx.dout}, {63'b0, m_rdc[63]});
    tick(10);
    chk("conflict_sticky", {63'b0, mx.conflict}, 64'd1);

    // strobe coincident with a hit and a readout shift
    hits(8'h04, 7);
    mx.strobe = 1'b1; mx.clk_sh = 1'b1; mx.din = 1'b1;
    tick(1);
    mx.hit = 8'h04;
    tick(1);
    mx.hit = 8'h00;
    m_rdc = packed_counts();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_cnt[2] = 1;
    mx.clk_sh = 1'b0; mx.strobe = 1'b0; tick(2);
    read_chain(w);
    chk("coinc_xfer", {56'b0, w[23:16]}, 64'd7);
    do_strobe();
    read_chain(w);
    chk("coinc_cnt", {56'b0, w[23:16]}, 64'd1);

    // randomized config with write_cfg coincident with the last shift
    mx.sh_b = 1'b0; mx.sh_a = 1'b1; tick(2);
    pat = {$urandom, $urandom};
    rr  = 10'($urandom);
    for (int k = 63; k >= 1; k--) shift_a(pat[k]);
    pre = m_cfgc;
    mx.res = rr; mx.write_cfg = 1'b1;
    shift_a(pat[0]);
    mx.write_cfg = 1'b0; tick(2);
    chk("rnd_wcfg_pre", mx.cfg, pre);
    chk("rnd_res", {54'b0, mx.res_q}, {54'b0, rr});
    m_cfg = pre;
    write_cfg_pulse(10'($urandom));
    chk("rnd_cfg", mx.cfg, pat);

    // randomized hit counts
    mx.sh_a = 1'b0; tick(2);
    for (int i = 0; i < 8; i++) n[i] = $urandom_range(0, 40);
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 8; i++) hp[i] = (c < n[i]);
      hits(hp, 1);
    end
    do_strobe();
    mx.sh_b = 1'b1; tick(2);
    read_chain(w);
    for (int i = 0; i < 8; i++)
      chk($sformatf("rnd_pix%0d", i), {56'b0, w[i*8 +: 8]}, 64'(n[i]));

    // reset mid config shift, write_cfg held through reset
    mx.sh_b = 1'b0; mx.sh_a = 1'b1; tick(2);
    for (int k = 0; k < 20; k++) shift_a(1'($urandom));
    mx.clk_sh = 1'b1; tick(1);
    rst = 1'b1; mx.write_cfg = 1'b1; mx.res = 10'h155;
    tick(1);
    chk("mid_rst_dout", {63'b0, mx.dout}, 64'd0);
    chk("mid_rst_cfg", mx.cfg, 64'd0);
    chk("mid_rst_res", {54'b0, mx.res_q}, 64'd0);
    chk("mid_rst_conf", {63'b0, mx.conflict}, 64'd0);
    rst = 1'b0; mx.clk_sh = 1'b0;
    tick(1);
    chk("post_rst_res1", {54'b0, mx.res_q}, 64'd0);
    tick(1);
    chk("post_rst_res2", {54'b0, mx.res_q}, 64'h155);
    chk("post_rst_cfg", mx.cfg, 64'd0);
    chk("post_rst_dout", {63'b0, mx.dout}, 64'd0);
    mx.write_cfg = 1'b0; tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
